// File: rtl/circle.sv
//------------------------------------------------------------------------------
// circle
// Midpoint circle rasteriser: draws one circle into a VGA frame buffer,
// emitting one pixel per cycle in fixed octant order with screen clipping.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module circle #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [7:0] radius,
   input  logic [2:0] colour,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLOT   = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic signed [9:0] SCR_W = 10'(SCREEN_W);
   localparam logic signed [9:0] SCR_H = 10'(SCREEN_H);

   logic [1:0]         state_q, state_d;
   logic [2:0]         octant_q, octant_d;
   logic [7:0]         cx_q, cx_d;
   logic [6:0]         cy_q, cy_d;
   logic [2:0]         colour_q, colour_d;
   logic signed [9:0]  ox_q, ox_d;
   logic signed [9:0]  oy_q, oy_d;
   logic signed [11:0] crit_q, crit_d;

   // Centre promoted to signed so negative offsets produce negative points
   logic signed [9:0]  cx_s, cy_s;
   logic signed [9:0]  px, py;
   logic               on_screen;
   logic signed [9:0]  oy_inc, ox_dec, ox_upd;
   logic signed [11:0] oy_inc_w, ox_dec_w, crit_upd;

   assign cx_s     = signed'({2'b00, cx_q});
   assign cy_s     = signed'({3'b000, cy_q});
   assign oy_inc   = oy_q + 10'sd1;
   assign ox_dec   = ox_q - 10'sd1;
   assign oy_inc_w = signed'({{2{oy_inc[9]}}, oy_inc});
   assign ox_dec_w = signed'({{2{ox_dec[9]}}, ox_dec});

   // Select the symmetric point for the current octant slot
   always_comb begin
      px = cx_s;
      py = cy_s;
      case (octant_q)
         3'd0: begin px = cx_s + ox_q; py = cy_s + oy_q; end
         3'd1: begin px = cx_s + oy_q; py = cy_s + ox_q; end
         3'd2: begin px = cx_s - ox_q; py = cy_s + oy_q; end
         3'd3: begin px = cx_s - oy_q; py = cy_s + ox_q; end
         3'd4: begin px = cx_s - ox_q; py = cy_s - oy_q; end
         3'd5: begin px = cx_s - oy_q; py = cy_s - ox_q; end
         3'd6: begin px = cx_s + ox_q; py = cy_s - oy_q; end
         default: begin px = cx_s + oy_q; py = cy_s - ox_q; end
      endcase
   end

   // Clipped slots still take a cycle; only the write strobe is suppressed
   assign on_screen  = !px[9] && !py[9] && (px < SCR_W) && (py < SCR_H);
   assign vga_plot   = (state_q == S_PLOT) && on_screen;
   assign vga_x      = (state_q == S_PLOT) ? px[7:0] : 8'd0;
   assign vga_y      = (state_q == S_PLOT) ? py[6:0] : 7'd0;
   assign vga_colour = colour_q;
   assign done       = (state_q == S_DONE);

   // Midpoint decision step, using the already-incremented offset_y
   always_comb begin
      if (crit_q <= 12'sd0) begin
         ox_upd   = ox_q;
         crit_upd = crit_q + (oy_inc_w <<< 1) + 12'sd1;
      end else begin
         ox_upd   = ox_dec;
         crit_upd = crit_q + ((oy_inc_w - ox_dec_w) <<< 1) + 12'sd1;
      end
   end

   // Next-state and datapath update for the IDLE/PLOT/UPDATE/DONE sequence
   always_comb begin
      state_d  = state_q;
      octant_d = octant_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      colour_d = colour_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      crit_d   = crit_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cx_d     = centre_x;
               cy_d     = centre_y;
               colour_d = colour;
               ox_d     = signed'({2'b00, radius});
               oy_d     = 10'sd0;
               crit_d   = 12'sd1 - signed'({4'b0000, radius});
               octant_d = 3'd0;
               state_d  = S_PLOT;
            end
         end
         S_PLOT: begin
            octant_d = octant_q + 3'd1;
            if (octant_q == 3'd7) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            oy_d    = oy_inc;
            ox_d    = ox_upd;
            crit_d  = crit_upd;
            state_d = (oy_inc <= ox_upd) ? S_PLOT : S_DONE;
         end
         default: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         octant_q <= 3'd0;
         cx_q     <= 8'd0;
         cy_q     <= 7'd0;
         colour_q <= 3'd0;
         ox_q     <= 10'sd0;
         oy_q     <= 10'sd0;
         crit_q   <= 12'sd0;
      end else begin
         state_q  <= state_d;
         octant_q <= octant_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         colour_q <= colour_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         crit_q   <= crit_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_circle.sv
//------------------------------------------------------------------------------
// tb_circle
// Scoreboard bench for the circle rasteriser: a reference model predicts the
// visible pixels (with their cycle) and the done cycle; a monitor checks them.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_circle;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] centre_x = 8'd0;
   logic [6:0] centre_y = 7'd0;
   logic [7:0] radius = 8'd0;
   logic [2:0] colour = 3'd0;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   circle #(.SCREEN_W(160), .SCREEN_H(120)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .centre_x   (centre_x),
      .centre_y   (centre_y),
      .radius     (radius),
      .colour     (colour),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   always #5 clk = ~clk;

   // Edge counter: after the k-th rising edge cyc == k
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int x;
      int y;
      int c;
      int cx;
      int cy;
      int r;
   } pix_t;

   pix_t pq[$];
   int   dq[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string name, input bit ok, input longint act, input longint exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: walk the circle octant by octant, predict visible pixels
   function automatic int model(input int cx, input int cy, input int r, input int col, input int s);
      int x, y, d, n;
      int px[8];
      int py[8];
      pix_t p;
      x = r; y = 0; d = 1 - r; n = 0;
      do begin
         px = '{cx + x, cx + y, cx - x, cx - y, cx - x, cx - y, cx + x, cx + y};
         py = '{cy + y, cy + x, cy + y, cy + x, cy - y, cy - x, cy - y, cy - x};
         for (int j = 0; j < 8; j++) begin
            if (px[j] >= 0 && px[j] < 160 && py[j] >= 0 && py[j] < 120) begin
               p.cyc = s + 9 * n + j;
               p.x = px[j]; p.y = py[j]; p.c = col;
               p.cx = cx; p.cy = cy; p.r = r;
               pq.push_back(p);
            end
         end
         n++;
         y++;
         if (d <= 0) d += 2 * y + 1;
         else begin
            x--;
            d += 2 * (y - x) + 1;
         end
      end while (y <= x);
      return n;
   endfunction

   // Monitor: compare every strobe and every done rising edge with the queues
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      pix_t   e;
      longint a, b, g;
      if (vga_plot) begin
         if (pq.size() == 0) begin
            chk("unexpected_plot", 1'b0, {vga_x, vga_y}, 0);
         end else begin
            e = pq.pop_front();
            a = (longint'(cyc) << 18) | (longint'(vga_x) << 10) | (longint'(vga_y) << 3) | longint'(vga_colour);
            b = (longint'(e.cyc) << 18) | (longint'(e.x) << 10) | (longint'(e.y) << 3) | longint'(e.c);
            chk("pixel", a == b, a, b);
            g = (longint'(vga_x) - e.cx) ** 2 + (longint'(vga_y) - e.cy) ** 2 - longint'(e.r) * e.r;
            chk("geometry", (g <= 2 * e.r + 1) && (g >= -(2 * e.r + 1)), g, 0);
         end
      end
      if (done && !done_prev) begin
         if (dq.size() == 0) chk("unexpected_done", 1'b0, cyc, 0);
         else begin
            b = dq.pop_front();
            chk("done_cycle", longint'(cyc) == b, cyc, b);
         end
      end
      if (done) chk("plot_in_done", vga_plot == 1'b0, vga_plot, 0);
      done_prev = done;
   end

   task automatic idle_outputs(input string tag);
      chk({tag, "_done"}, done == 1'b0, done, 0);
      chk({tag, "_plot"}, vga_plot == 1'b0, vga_plot, 0);
      chk({tag, "_xyc"}, {vga_x, vga_y, vga_colour} == 18'd0, {vga_x, vga_y, vga_colour}, 0);
   endtask

   // Issue one draw; optionally drop start and scramble inputs mid-draw
   task automatic run_draw(input int cx, input int cy, input int r, input int col, input bit perturb);
      int  s, n, k;
      bit  seen;
      @(negedge clk); #1;
      centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = 3'(col);
      start = 1'b1;
      s = cyc + 1;
      n = model(cx, cy, r, col, s);
      dq.push_back(s + 9 * n);
      k = $urandom_range(1, 9 * n);
      seen = 1'b0;
      for (int i = 1; i <= 9 * n + 5; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
         if (perturb && i == k) begin
            #1;
            start = 1'b0;
            centre_x = 8'($urandom); centre_y = 7'($urandom);
            radius = 8'($urandom); colour = 3'($urandom);
         end
      end
      chk("done_seen", seen, seen, 1);
      if (!seen) begin
         #1 rst = 1'b1; start = 1'b0;
         @(negedge clk); #1 rst = 1'b0;
         pq.delete(); dq.delete();
         return;
      end
      if (start) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("done_held", done == 1'b1, done, 1);
         end
         #1 start = 1'b0;
      end
      @(negedge clk);
      chk("done_clear", done == 1'b0, done, 0);
   endtask

   initial begin
      int s, k, re;
      repeat (3) @(negedge clk);
      idle_outputs("reset");
      #1 rst = 1'b0;
      @(negedge clk);
      idle_outputs("idle");

      run_draw(80, 60, 0, 2, 1'b0);
      run_draw(80, 60, 1, 5, 1'b0);
      run_draw(80, 60, 40, 7, 1'b0);
      run_draw(5, 5, 30, 4, 1'b0);
      run_draw(150, 110, 200, 1, 1'b0);

      // Reset during the third iteration of an r=40 circle
      @(negedge clk); #1;
      centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd6;
      start = 1'b1;
      s = cyc + 1;
      void'(model(80, 60, 40, 6, s));
      dq.push_back(-1);
      k = $urandom_range(0, 8);
      repeat (19 + k) @(negedge clk);
      #1 rst = 1'b1; start = 1'b0;
      re = cyc + 1;
      while (pq.size() > 0 && pq[$].cyc >= re) void'(pq.pop_back());
      void'(dq.pop_back());
      @(negedge clk);
      idle_outputs("midreset");
      #1 rst = 1'b0;
      @(negedge clk);
      idle_outputs("postreset");
      run_draw(80, 60, 40, 3, 1'b0);

      run_draw(80, 60, 20, 2, 1'b1);
      run_draw(80, 60, 0, 1, 1'b1);

      for (int t = 0; t < 14; t++) begin
         run_draw($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 255),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("pixels_left", pq.size() == 0, pq.size(), 0);
      chk("dones_left", dq.size() == 0, dq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Global watchdog so the bench always terminates
   initial begin
      #3000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
